// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - FIR operand sequencer: delay line, coefficient bank, tagged tap pairs
module fir_tap_sequencer #(
   parameter int NTAPS = 8,
   parameter int DW    = 16,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_sample,
   input  logic          coef_we,
   input  logic [AW-1:0] coef_addr,
   input  logic [DW-1:0] coef_wdata,
   output logic          op_valid,
   input  logic          op_ready,
   output logic [DW-1:0] op_a,
   output logic [DW-1:0] op_b,
   output logic          op_first,
   output logic          op_last,
   output logic          busy
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);

   state_t        state;
   state_t        state_nxt;

   logic [DW-1:0] delay_line [NTAPS];
   logic [DW-1:0] coef_bank  [NTAPS];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] base;
   logic [AW-1:0] tap_idx;
   logic          rst_done;

   logic          accept;
   logic          advance;
   logic          finish;
   logic          coef_wr_ok;
   logic [AW-1:0] nxt_idx;
   logic [AW-1:0] rd_idx;
   logic [DW-1:0] coef0_fwd;

   // in_ready stays low until the first clock after reset release, so it reads 0 while held in reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_done <= 1'b0;
      end else begin
         rst_done <= 1'b1;
      end
   end

   assign busy       = (state == RUN);
   assign in_ready   = rst_done && (state == IDLE);
   assign accept     = in_valid && in_ready;
   assign advance    = (state == RUN) && op_ready;
   assign finish     = advance && (tap_idx == LAST_TAP);
   assign coef_wr_ok = coef_we && !busy;

   // Read-address arithmetic for the next pair; AW-bit subtraction wraps the delay line for free
   always_comb begin
      nxt_idx   = tap_idx + 1'b1;
      rd_idx    = base - nxt_idx;
      coef0_fwd = coef_bank[0];
      if (coef_we && (coef_addr == '0)) begin
         coef0_fwd = coef_wdata;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state: one sample in IDLE, NTAPS accepted pairs in RUN
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (finish) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Coefficient bank; writes are locked out while a sample is being sequenced
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NTAPS; i++) begin
            coef_bank[i] <= '0;
         end
      end else if (coef_wr_ok) begin
         coef_bank[coef_addr] <= coef_wdata;
      end
   end

   // Sample delay line; one entry written per accepted sample
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NTAPS; i++) begin
            delay_line[i] <= '0;
         end
      end else if (accept) begin
         delay_line[wr_ptr] <= in_sample;
      end
   end

   // Sequencing pointers: base freezes the newest sample slot, tap_idx walks the taps
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         base    <= '0;
         tap_idx <= '0;
      end else if (accept) begin
         base    <= wr_ptr;
         tap_idx <= '0;
      end else if (finish) begin
         wr_ptr  <= wr_ptr + 1'b1;
         tap_idx <= '0;
      end else if (advance) begin
         tap_idx <= nxt_idx;
      end
   end

   // Registered operand pair; tap 0 bypasses the delay line and a same-cycle coef[0] write
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_valid <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         op_first <= 1'b0;
         op_last  <= 1'b0;
      end else if (accept) begin
         op_valid <= 1'b1;
         op_a     <= in_sample;
         op_b     <= coef0_fwd;
         op_first <= 1'b1;
         op_last  <= (LAST_TAP == '0);
      end else if (finish) begin
         op_valid <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         op_first <= 1'b0;
         op_last  <= 1'b0;
      end else if (advance) begin
         op_valid <= 1'b1;
         op_a     <= delay_line[rd_idx];
         op_b     <= coef_bank[nxt_idx];
         op_first <= 1'b0;
         op_last  <= (nxt_idx == LAST_TAP);
      end
   end

endmodule
